// File: rtl/gpr_dump_pkg.sv
// Shared types and constants for the GPR readout unit: FSM encoding,
// default widths and the register index range covered by a dump.
package gpr_dump_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_ADDR_W  = 5;
  localparam int DEF_REG_CNT = 32;

  // Register 0 is hard-wired to zero in MIPS, so the dump starts at 1.
  localparam int FIRST_REG = 1;
  localparam int LAST_REG  = DEF_REG_CNT - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage : gpr_dump_pkg

// File: rtl/gpr_dump.sv
// GPR readout unit: walks registers 1..REG_CNT-1 through a dedicated read
// port, compares each word with an expected ROM, streams records, keeps a verdict.
module gpr_dump
  import gpr_dump_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int REG_CNT = DEF_REG_CNT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic [ADDR_W-1:0] rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic [ADDR_W-1:0] exp_addr,
  input  logic [DATA_W-1:0] exp_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_idx,
  output logic [DATA_W-1:0] out_data,
  output logic              out_mismatch,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_idx,
  output logic [ADDR_W:0]   mismatch_cnt
);

  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(FIRST_REG);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(REG_CNT - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] idx;

  logic launch;     // start accepted (IDLE or DONE)
  logic capture;    // sample register and expected word
  logic handshake;  // record consumed
  logic finish;     // last record consumed
  logic word_diff;

  assign rf_raddr  = idx;
  assign exp_addr  = idx;
  assign word_diff = (rf_rdata != exp_data);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  // NOTE: every variable written in an always_comb gets a default first, so
  // no path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (launch) state_nxt = READ;
      READ:    state_nxt = HOLD;
      HOLD:    if (handshake) state_nxt = finish ? DONE : READ;
      DONE:    if (launch) state_nxt = READ;
      default: state_nxt = IDLE;
    endcase
  end

  // Control strobes decoded from the current state; start while busy falls
  // through here as a no-op because launch only fires in IDLE or DONE.
  always_comb begin
    launch    = 1'b0;
    capture   = 1'b0;
    handshake = 1'b0;
    finish    = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE: launch = start;
      READ: begin
        capture = 1'b1;
        busy    = 1'b1;
      end
      HOLD: begin
        handshake = out_valid & out_ready;
        finish    = out_valid & out_ready & (idx == LAST_IDX);
        busy      = 1'b1;
      end
      DONE: launch = start;
      default: ;
    endcase
  end

  // Index counter, record capture and verdict registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the fail_idx test reads the old mismatch_cnt.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx          <= FIRST_IDX;
      out_valid    <= 1'b0;
      out_idx      <= '0;
      out_data     <= '0;
      out_mismatch <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      fail_idx     <= '0;
      mismatch_cnt <= '0;
    end else begin
      if (launch) begin
        idx          <= FIRST_IDX;
        mismatch_cnt <= '0;
        fail_idx     <= '0;
        done         <= 1'b0;
      end

      if (capture) begin
        out_data     <= rf_rdata;
        out_idx      <= idx;
        out_mismatch <= word_diff;
        out_valid    <= 1'b1;
        if (word_diff) begin
          mismatch_cnt <= mismatch_cnt + 1'b1;
          if (mismatch_cnt == '0) fail_idx <= idx;
        end
      end

      if (handshake) begin
        out_valid <= 1'b0;
        if (finish) begin
          done <= 1'b1;
          pass <= (mismatch_cnt == '0);
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

endmodule : gpr_dump

// File: tb/tb_gpr_dump.sv
// Self-checking bench for gpr_dump: directed scenarios plus randomized dumps
// checked against a record-list model built from the register/ROM contents.
module tb_gpr_dump;

  localparam int NREG = 32;
  localparam int LAST = NREG - 1;

  logic        clk;
  logic        reset;
  logic        start;
  logic        busy;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic [4:0]  exp_addr;
  logic [31:0] exp_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_idx;
  logic [31:0] out_data;
  logic        out_mismatch;
  logic        done;
  logic        pass;
  logic [4:0]  fail_idx;
  logic [5:0]  mismatch_cnt;

  logic [31:0] gpr  [0:NREG-1];
  logic [31:0] expm [0:NREG-1];
  logic [31:0] mval [0:NREG-1];
  logic        mmm  [0:NREG-1];

  int checks = 0;
  int errors = 0;

  assign rf_rdata = gpr[rf_raddr];
  assign exp_data = expm[exp_addr];

  gpr_dump dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .exp_addr(exp_addr), .exp_data(exp_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_data(out_data), .out_mismatch(out_mismatch),
    .done(done), .pass(pass), .fail_idx(fail_idx), .mismatch_cnt(mismatch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_mm"}, out_mismatch, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_oidx"}, out_idx, 0);
    check({tag, "_odata"}, out_data, 0);
    check({tag, "_fidx"}, fail_idx, 0);
    check({tag, "_cnt"}, mismatch_cnt, 0);
    check({tag, "_raddr"}, rf_raddr, 1);
  endtask

  task automatic fill_match();
    for (int i = 0; i < NREG; i++) begin
      gpr[i]  = 32'(i * 3);
      expm[i] = 32'(i * 3);
    end
    gpr[0]  = 32'h1;
    expm[0] = 32'h2;
  endtask

  task automatic fill_random();
    for (int i = 0; i < NREG; i++) begin
      gpr[i]  = $urandom;
      expm[i] = ($urandom_range(0, 3) == 0) ? (gpr[i] ^ ($urandom | 32'h1)) : gpr[i];
    end
  endtask

  task automatic do_start(input string tag);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_start_busy"}, busy, 1);
    check({tag, "_start_done"}, done, 0);
    check({tag, "_start_cnt"}, mismatch_cnt, 0);
    check({tag, "_start_fidx"}, fail_idx, 0);
  endtask

  // Runs one dump from the start pulse. Options (-1 disables):
  // bp_idx/bp_len stall the given record; busy_idx re-pulses start during it;
  // rst_idx asserts reset while it is held; hw_idx rewrites the GPR during its HOLD.
  task automatic run_dump(input string tag, input int bp_idx, input int bp_len,
                          input bit rand_ready, input int busy_idx,
                          input int rst_idx, input int hw_idx);
    int edges, stalls, nrec, bp_left, exp_cnt, exp_first;
    bit held, injected, hw_done;
    logic [4:0]  h_idx;
    logic [31:0] h_data;
    logic        h_mm;

    for (int i = 1; i < NREG; i++) begin
      mval[i] = gpr[i];
      mmm[i]  = (gpr[i] != expm[i]);
    end
    edges = 0; stalls = 0; nrec = 0; bp_left = bp_len;
    held = 0; injected = 0; hw_done = 0;
    h_idx = '0; h_data = '0; h_mm = 1'b0;
    do_start(tag);

    forever begin
      if (rand_ready)
        out_ready = ($urandom_range(0, 3) != 0);
      else if (out_valid && int'(out_idx) == bp_idx && bp_left > 0) begin
        out_ready = 1'b0;
        bp_left--;
      end else
        out_ready = 1'b1;

      if (out_valid && int'(out_idx) == rst_idx) begin
        reset = 1'b0;
        #1;
        check_reset_vals({tag, "_midreset"});
        @(negedge clk);
        return;
      end

      if (out_valid && int'(out_idx) == busy_idx && !injected) begin
        start = 1'b1;
        injected = 1;
      end

      if (out_valid && int'(out_idx) == hw_idx && !hw_done) begin
        gpr[hw_idx]     = ~gpr[hw_idx];
        gpr[hw_idx + 1] = $urandom;
        mval[hw_idx + 1] = gpr[hw_idx + 1];
        mmm[hw_idx + 1]  = (gpr[hw_idx + 1] != expm[hw_idx + 1]);
        hw_done = 1;
      end

      check({tag, "_exp_addr"}, exp_addr, rf_raddr);
      if (out_valid) begin
        if (held) begin
          check({tag, "_hold_idx"}, out_idx, h_idx);
          check({tag, "_hold_data"}, out_data, h_data);
          check({tag, "_hold_mm"}, out_mismatch, h_mm);
        end
        if (out_ready) begin
          nrec++;
          check({tag, "_rec_idx"}, out_idx, nrec);
          check({tag, "_rec_data"}, out_data, mval[nrec < NREG ? nrec : LAST]);
          check({tag, "_rec_mm"}, out_mismatch, mmm[nrec < NREG ? nrec : LAST]);
          held = 0;
        end else begin
          stalls++;
          held = 1;
          h_idx = out_idx; h_data = out_data; h_mm = out_mismatch;
        end
      end else
        held = 0;

      @(posedge clk);
      edges++;
      @(negedge clk);
      start = 1'b0;
      if (done) break;
      if (edges > 1000) begin
        check({tag, "_timeout_done"}, done, 1);
        break;
      end
    end

    exp_cnt = 0;
    exp_first = 0;
    for (int i = 1; i < NREG; i++)
      if (mmm[i]) begin
        if (exp_cnt == 0) exp_first = i;
        exp_cnt++;
      end
    check({tag, "_latency"}, edges, 2 * LAST + stalls);
    check({tag, "_nrec"}, nrec, LAST);
    check({tag, "_end_busy"}, busy, 0);
    check({tag, "_end_valid"}, out_valid, 0);
    check({tag, "_pass"}, pass, exp_cnt == 0);
    check({tag, "_fidx"}, fail_idx, exp_first);
    check({tag, "_cnt"}, mismatch_cnt, exp_cnt);
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    out_ready = 1'b1;
    fill_match();
    #23;
    check_reset_vals("por");
    @(negedge clk);
    reset = 1'b1;

    run_dump("all_match", -1, 0, 0, -1, -1, -1);

    fill_match();
    gpr[5]  = 32'h0000_0008;
    expm[5] = 32'h0000_0005;
    run_dump("single_mm", -1, 0, 0, -1, -1, -1);

    fill_match();
    gpr[7]  = 32'hDEAD_0007;
    gpr[12] = 32'hBEEF_000C;
    gpr[31] = 32'hFFFF_FFFF;
    run_dump("multi_mm", -1, 0, 0, -1, -1, -1);
    check("multi_last_idx", out_idx, 31);
    check("multi_last_mm", out_mismatch, 1);

    fill_match();
    run_dump("backpressure", 4, 3, 0, -1, -1, -1);

    // Start during idx 10 is ignored; the following dump restarts from DONE.
    run_dump("busy_start", -1, 0, 0, 10, -1, -1);
    gpr[3] = 32'h1234_5678;
    run_dump("restart", -1, 0, 0, -1, -1, -1);

    fill_match();
    run_dump("reset_mid", -1, 0, 0, -1, 15, -1);
    reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("post_reset_idle_valid", out_valid, 0);
      check("post_reset_idle_busy", busy, 0);
    end
    run_dump("after_reset", -1, 0, 0, -1, -1, -1);

    for (int r = 0; r < 6; r++) begin
      fill_random();
      run_dump("random", -1, 0, 1, -1, -1, int'($urandom_range(1, LAST - 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_gpr_dump
